// File: rtl/ulpi_axis_pkt_fifo.sv
// Packet FIFO for ULPI AXI-Stream paths: store-and-forward with drop of
// errored/oversized packets, or a plain stream FIFO when PACKET_MODE=0.
module ulpi_axis_pkt_fifo #(
  parameter int DATA_W      = 8,
  parameter int USER_W      = 2,
  parameter int DEPTH       = 64,
  parameter int PACKET_MODE = 1,
  parameter int ERR_BIT     = 0,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  input  logic [USER_W-1:0]          s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  output logic [USER_W-1:0]          m_tuser,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       overflow,
  output logic                       err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + USER_W + 1;
  localparam logic [PW-1:0] ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_tmp;
  logic [PW-1:0] wr_vis;
  logic [PW-1:0] rd_ptr;
  logic          err;
  logic [EW-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic acc;
  logic we;
  logic load;
  logic err_n;
  logic drop;

  assign full  = (wr_tmp[AW] != rd_ptr[AW]) &&
                 (wr_tmp[AW-1:0] == rd_ptr[AW-1:0]);
  // read side sees commits one cycle late, giving a two-edge latency
  assign empty = rd_ptr == wr_vis;
  assign acc   = s_tvalid && s_tready;
  assign we    = acc && !full && (state != DROP);
  assign load  = !empty && (!m_tvalid || m_tready);
  assign err_n = err || s_tuser[ERR_BIT];
  assign count = wr_ptr - rd_ptr;

  assign drop = (PACKET_MODE != 0) && acc && (state != DROP) &&
                (full || (s_tlast && err_n));

  always_comb begin
    s_tready = 1'b0;
    if (!rst) begin
      if (PACKET_MODE == 0)
        s_tready = !full;
      else
        s_tready = (state == DROP) || !full || (wr_tmp != wr_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_tmp[AW-1:0]] <= {s_tlast, s_tuser, s_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_tmp     <= '0;
      wr_vis     <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      err_drop   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_vis   <= wr_ptr;
      overflow <= drop && full;
      err_drop <= drop && !full;
      if (drop && (drop_count != '1))
        drop_count <= drop_count + CNT_ONE;
      if (PACKET_MODE == 0) begin
        if (acc) begin
          wr_tmp <= wr_tmp + ONE;
          wr_ptr <= wr_tmp + ONE;
        end
      end else begin
        case (state)
          IDLE, FILL: begin
            if (acc) begin
              if (full) begin
                wr_tmp <= wr_ptr;
                err    <= 1'b0;
                state  <= s_tlast ? IDLE : DROP;
              end else if (s_tlast) begin
                err   <= 1'b0;
                state <= IDLE;
                if (err_n) begin
                  wr_tmp <= wr_ptr;
                end else begin
                  wr_tmp <= wr_tmp + ONE;
                  wr_ptr <= wr_tmp + ONE;
                end
              end else begin
                wr_tmp <= wr_tmp + ONE;
                err    <= err_n;
                state  <= FILL;
              end
            end
          end
          DROP: begin
            if (acc && s_tlast)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
    end else if (load) begin
      {m_tlast, m_tuser, m_tdata} <= mem[rd_ptr[AW-1:0]];
      m_tvalid <= 1'b1;
      rd_ptr   <= rd_ptr + ONE;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ulpi_axis_pkt_fifo.sv
// Directed bench: packet-mode FIFO (DEPTH=8, CNT_W=8) and stream-mode FIFO.
// Cycle tables for exact timing plus sequences for fill, reset, saturation.
module tb_ulpi_axis_pkt_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       p_s_tvalid, p_s_tready, p_s_tlast;
  logic [7:0] p_s_tdata;
  logic [1:0] p_s_tuser;
  logic       p_m_tvalid, p_m_tready, p_m_tlast;
  logic [7:0] p_m_tdata;
  logic [1:0] p_m_tuser;
  logic [3:0] p_count;
  logic [7:0] p_drop_count;
  logic       p_overflow, p_err_drop;

  logic       q_s_tvalid, q_s_tready, q_s_tlast;
  logic [7:0] q_s_tdata;
  logic [1:0] q_s_tuser;
  logic       q_m_tvalid, q_m_tready, q_m_tlast;
  logic [7:0] q_m_tdata;
  logic [1:0] q_m_tuser;
  logic [3:0] q_count;
  logic [7:0] q_drop_count;
  logic       q_overflow, q_err_drop;

  ulpi_axis_pkt_fifo #(
    .DATA_W(8), .USER_W(2), .DEPTH(8),
    .PACKET_MODE(1), .ERR_BIT(0), .CNT_W(8)
  ) dp (
    .clk(clk), .rst(rst),
    .s_tvalid(p_s_tvalid), .s_tready(p_s_tready),
    .s_tdata(p_s_tdata), .s_tlast(p_s_tlast), .s_tuser(p_s_tuser),
    .m_tvalid(p_m_tvalid), .m_tready(p_m_tready),
    .m_tdata(p_m_tdata), .m_tlast(p_m_tlast), .m_tuser(p_m_tuser),
    .count(p_count), .drop_count(p_drop_count),
    .overflow(p_overflow), .err_drop(p_err_drop)
  );

  ulpi_axis_pkt_fifo #(
    .DATA_W(8), .USER_W(2), .DEPTH(8),
    .PACKET_MODE(0), .ERR_BIT(0), .CNT_W(8)
  ) ds (
    .clk(clk), .rst(rst),
    .s_tvalid(q_s_tvalid), .s_tready(q_s_tready),
    .s_tdata(q_s_tdata), .s_tlast(q_s_tlast), .s_tuser(q_s_tuser),
    .m_tvalid(q_m_tvalid), .m_tready(q_m_tready),
    .m_tdata(q_m_tdata), .m_tlast(q_m_tlast), .m_tuser(q_m_tuser),
    .count(q_count), .drop_count(q_drop_count),
    .overflow(q_overflow), .err_drop(q_err_drop)
  );

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       last;
    logic [1:0] u;
    logic       rdy;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic [1:0] mu;
    logic       sr;
    logic [3:0] cnt;
    logic [7:0] dc;
    logic       ov;
    logic       ed;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic add(
    input logic vld, input logic [7:0] d, input logic last,
    input logic [1:0] u, input logic rdy,
    input logic mv, input logic [7:0] md, input logic ml,
    input logic [1:0] mu, input logic sr, input logic [3:0] cnt,
    input logic [7:0] dc, input logic ov, input logic ed);
    vec_t v;
    v.vld = vld; v.d = d; v.last = last; v.u = u; v.rdy = rdy;
    v.mv = mv; v.md = md; v.ml = ml; v.mu = mu; v.sr = sr;
    v.cnt = cnt; v.dc = dc; v.ov = ov; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic p_send(input logic [7:0] d, input logic last,
                        input logic [1:0] u);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      p_s_tvalid = 1'b1;
      p_s_tdata  = d;
      p_s_tlast  = last;
      p_s_tuser  = u;
      if (p_s_tready) return;
    end
    timeout("p_send");
  endtask

  task automatic p_idle();
    @(negedge clk);
    p_s_tvalid = 1'b0;
    p_s_tlast  = 1'b0;
    p_s_tuser  = 2'b0;
  endtask

  task automatic p_expect(input logic [7:0] d, input logic last,
                          input logic [1:0] u, input string nm);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      p_m_tready = 1'b1;
      if (p_m_tvalid) begin
        check(nm, {p_m_tlast, p_m_tuser, p_m_tdata}, {last, u, d});
        return;
      end
    end
    timeout(nm);
  endtask

  initial begin
    logic [26:0] act, exp;
    logic        seen;
    int          sent, rcv, pulses;

    p_s_tvalid = 0; p_s_tdata = 0; p_s_tlast = 0; p_s_tuser = 0;
    p_m_tready = 0;
    q_s_tvalid = 0; q_s_tdata = 0; q_s_tlast = 0; q_s_tuser = 0;
    q_m_tready = 0;

    // 5-beat clean packet, then exact output timing
    add(1,8'h11,0,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h12,0,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h13,0,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h14,0,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h15,1,0,1, 0,0,0,0,1,0,0,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,5,0,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,5,0,0,0);
    add(0,8'h00,0,0,1, 1,8'h11,0,0,1,4,0,0,0);
    add(0,8'h00,0,0,1, 1,8'h12,0,0,1,3,0,0,0);
    add(0,8'h00,0,0,1, 1,8'h13,0,0,1,2,0,0,0);
    add(0,8'h00,0,0,1, 1,8'h14,0,0,1,1,0,0,0);
    add(0,8'h00,0,0,1, 1,8'h15,1,0,1,0,0,0,0);
    // errored 3-beat packet, then clean 2-beat with tuser[1] set
    add(1,8'h31,0,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h32,0,1,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h33,1,0,1, 0,0,0,0,1,0,0,0,0);
    add(1,8'h41,0,2,1, 0,0,0,0,1,0,1,0,1);
    add(1,8'h42,1,2,1, 0,0,0,0,1,0,1,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,2,1,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,2,1,0,0);
    add(0,8'h00,0,0,1, 1,8'h41,0,2,1,1,1,0,0);
    add(0,8'h00,0,0,1, 1,8'h42,1,2,1,0,1,0,0);
    // 12-beat oversized packet with consumer stalled
    add(1,8'h51,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h52,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h53,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h54,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h55,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h56,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h57,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h58,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h59,0,0,0, 0,0,0,0,1,0,1,0,0);
    add(1,8'h5A,0,0,0, 0,0,0,0,1,0,2,1,0);
    add(1,8'h5B,0,0,0, 0,0,0,0,1,0,2,0,0);
    add(1,8'h5C,1,0,0, 0,0,0,0,1,0,2,0,0);
    add(1,8'h61,0,0,1, 0,0,0,0,1,0,2,0,0);
    add(1,8'h62,0,0,1, 0,0,0,0,1,0,2,0,0);
    add(1,8'h63,0,0,1, 0,0,0,0,1,0,2,0,0);
    add(1,8'h64,1,0,1, 0,0,0,0,1,0,2,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,4,2,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,4,2,0,0);
    add(0,8'h00,0,0,1, 1,8'h61,0,0,1,3,2,0,0);
    add(0,8'h00,0,0,1, 1,8'h62,0,0,1,2,2,0,0);
    add(0,8'h00,0,0,1, 1,8'h63,0,0,1,1,2,0,0);
    add(0,8'h00,0,0,1, 1,8'h64,1,0,1,0,2,0,0);
    add(0,8'h00,0,0,1, 0,0,0,0,1,0,2,0,0);

    repeat (2) @(negedge clk);
    check("rst_p_sready", p_s_tready, 0);
    check("rst_q_sready", q_s_tready, 0);
    check("rst_p_mvalid", p_m_tvalid, 0);
    check("rst_p_stat", {p_count, p_drop_count, p_overflow, p_err_drop}, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      act = {p_m_tvalid,
             p_m_tvalid ? {p_m_tlast, p_m_tuser, p_m_tdata} : 11'h0,
             p_s_tready, p_count, p_drop_count, p_overflow, p_err_drop};
      exp = {vq[i].mv,
             vq[i].mv ? {vq[i].ml, vq[i].mu, vq[i].md} : 11'h0,
             vq[i].sr, vq[i].cnt, vq[i].dc, vq[i].ov, vq[i].ed};
      check($sformatf("vec%0d", i), act, exp);
      p_s_tvalid = vq[i].vld;
      p_s_tdata  = vq[i].d;
      p_s_tlast  = vq[i].last;
      p_s_tuser  = vq[i].u;
      p_m_tready = vq[i].rdy;
    end

    // fill RAM with committed data while the consumer stalls
    @(negedge clk);
    p_s_tvalid = 1'b0;
    p_m_tready = 1'b0;
    for (int i = 0; i < 8; i++)
      p_send(8'(8'h71 + i), i == 7, 2'b0);
    p_send(8'h79, 1'b1, 2'b0);
    p_idle();
    repeat (4) @(negedge clk);
    check("full_sready", p_s_tready, 0);
    check("full_count", p_count, 8);
    check("full_head", {p_m_tvalid, p_m_tdata}, {1'b1, 8'h71});
    for (int i = 0; i < 9; i++)
      p_expect(8'(8'h71 + i), (i == 7) || (i == 8), 2'b0,
               $sformatf("drain%0d", i));
    repeat (2) @(negedge clk);
    check("drain_sready", p_s_tready, 1);
    check("drain_stat", {p_count, p_drop_count}, {4'd0, 8'd2});

    // stream mode: 32 beats, consumer ready every other cycle
    sent = 0;
    rcv = 0;
    seen = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 300 && rcv < 32; cyc++) begin
      @(negedge clk);
      q_s_tvalid = sent < 32;
      q_s_tdata  = 8'(sent);
      q_s_tuser  = 2'(sent);
      q_s_tlast  = (sent % 8) == 7;
      q_m_tready = cyc[0];
      check("st_sready", q_s_tready, q_count != 4'd8);
      if (q_count == 4'd8) seen = 1'b1;
      if (q_overflow || q_err_drop) pulses++;
      if (q_s_tvalid && q_s_tready) sent++;
      if (q_m_tvalid && q_m_tready) begin
        check($sformatf("st_beat%0d", rcv),
              {q_m_tlast, q_m_tuser, q_m_tdata},
              {(rcv % 8) == 7, 2'(rcv), 8'(rcv)});
        rcv++;
      end
    end
    if (rcv != 32) timeout("st_recv");
    @(negedge clk);
    q_s_tvalid = 1'b0;
    check("st_full_seen", seen, 1);
    check("st_no_drop", {q_drop_count, 8'(pulses)}, 0);

    // reset mid-packet while output register holds data
    @(negedge clk);
    p_m_tready = 1'b0;
    p_send(8'h81, 1'b0, 2'b0);
    p_send(8'h82, 1'b0, 2'b0);
    p_send(8'h83, 1'b1, 2'b0);
    p_send(8'h91, 1'b0, 2'b0);
    p_send(8'h92, 1'b0, 2'b0);
    p_idle();
    repeat (3) @(negedge clk);
    check("mid_mvalid", p_m_tvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sready", p_s_tready, 0);
    check("mrst_mout", {p_m_tvalid, p_m_tlast, p_m_tuser, p_m_tdata}, 0);
    check("mrst_count", p_count, 0);
    check("mrst_dcount", p_drop_count, 0);
    check("mrst_pulse", {p_overflow, p_err_drop}, 0);
    rst = 1'b0;
    seen = 1'b0;
    p_m_tready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (p_m_tvalid) seen = 1'b1;
    end
    check("mrst_flushed", seen, 0);
    p_send(8'hA5, 1'b1, 2'b0);
    p_idle();
    p_expect(8'hA5, 1'b1, 2'b0, "post_rst_pkt");
    repeat (3) @(negedge clk);
    check("post_rst_only", p_m_tvalid, 0);

    // errored single-beat packets drive drop_count into saturation
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (p_err_drop) pulses++;
      p_s_tvalid = 1'b1;
      p_s_tdata  = 8'hE0;
      p_s_tlast  = 1'b1;
      p_s_tuser  = 2'b01;
    end
    @(negedge clk);
    if (p_err_drop) pulses++;
    p_s_tvalid = 1'b0;
    check("sat_255", p_drop_count, 255);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (p_err_drop) pulses++;
      p_s_tvalid = 1'b1;
    end
    @(negedge clk);
    if (p_err_drop) pulses++;
    p_s_tvalid = 1'b0;
    @(negedge clk);
    check("sat_hold", p_drop_count, 255);
    check("err_pulses", pulses, 260);
    check("sat_no_out", {p_m_tvalid, p_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
